lane_dispatch_rr: RTL and testbench

LANE_DISPATCH_RR -- requirements
Module: lane_dispatch_rr

---
 rtl/lane_dispatch_rr.sv | 155 +++++++++++++++
 tb/tb_lane_dispatch_rr.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_dispatch_rr.sv
// ---------------------------------------------------------------------------
// LaneDispatchRr -- strict round-robin dispatcher of one upstream stream into
// NUM_LANES independent per-lane FIFOs.
//
// Each accepted input word goes to the lane named by rr_ptr. rr_ptr then
// advances by one and wraps to zero after the last lane. A full target lane
// stalls the input; no lane is ever skipped.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream word available
//   in_ready    block accepts in_data this cycle
//   in_data     upstream payload (DATA_W bits)
//   out_valid   per-lane word available (NUM_LANES bits)
//   out_ready   per-lane consumer accepts (NUM_LANES bits)
//   out_data    per-lane head word, lane i at [i*DATA_W +: DATA_W]
//   rr_ptr      lane that receives the next accepted word
//   accept_cnt  wrapping 16-bit count of accepted input words
//   idle        every lane FIFO is empty
// ---------------------------------------------------------------------------
module lane_dispatch_rr #(
  parameter int DATA_W     = 32,
  parameter int NUM_LANES  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [2:0]                    rr_ptr,
  output logic [15:0]                   accept_cnt,
  output logic                          idle
);

  // Pointer and occupancy widths. Depths that are not a power of two are
  // supported by an explicit wrap at the last index.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_LANE = 3'(NUM_LANES - 1);

  logic [DATA_W-1:0] mem_q [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]     wr_q  [NUM_LANES];
  logic [PW-1:0]     wr_d  [NUM_LANES];
  logic [PW-1:0]     rd_q  [NUM_LANES];
  logic [PW-1:0]     rd_d  [NUM_LANES];
  logic [CW-1:0]     cnt_q [NUM_LANES];
  logic [CW-1:0]     cnt_d [NUM_LANES];

  logic [2:0]           rr_q, rr_d;
  logic [15:0]          acc_q, acc_d;
  logic [NUM_LANES-1:0] full, empty, push, pop;
  logic                 accept;

  // Lane status decoded from registered occupancy only, so in_ready never
  // depends on in_valid or out_ready in the same cycle.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      full[i]  = (cnt_q[i] == FULL_CNT);
      empty[i] = (cnt_q[i] == '0);
    end
  end

  assign in_ready = !full[rr_q];

  // Transfers are suppressed while reset is high so in_valid/out_ready are
  // ignored during reset.
  assign accept = in_valid && in_ready && !rst;

  // Per-lane push/pop decode and next-state pointers/occupancy. A full lane
  // can never be pushed (in_ready low), even when it pops in the same cycle.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      push[i]  = accept && (rr_q == 3'(i));
      pop[i]   = out_ready[i] && !empty[i] && !rst;
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      cnt_d[i] = cnt_q[i];
      if (push[i]) begin
        wr_d[i] = (wr_q[i] == LAST_IDX) ? '0 : wr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_d[i] = (rd_q[i] == LAST_IDX) ? '0 : rd_q[i] + PW'(1);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Round-robin pointer advances only on an accepted word; the accept
  // counter wraps naturally at 16 bits.
  always_comb begin
    rr_d  = rr_q;
    acc_d = acc_q;
    if (accept) begin
      rr_d  = (rr_q == LAST_LANE) ? 3'd0 : rr_q + 3'd1;
      acc_d = acc_q + 16'd1;
    end
  end

  // Control state with synchronous reset; clearing occupancy is enough to
  // discard everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= 3'd0;
      acc_q <= 16'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q  <= rr_d;
      acc_q <= acc_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once
  // occupancy is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        mem_q[i][wr_q[i]] <= in_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
    assign out_valid[g]                  = !empty[g];
    assign out_data[g*DATA_W +: DATA_W]  = mem_q[g][rd_q[g]];
  end

  assign rr_ptr     = rr_q;
  assign accept_cnt = acc_q;
  assign idle       = &empty;

endmodule

// File: tb/tb_lane_dispatch_rr.sv
// ---------------------------------------------------------------------------
// tb_lane_dispatch_rr -- directed, table-driven bench for lane_dispatch_rr
// (DATA_W=32, NUM_LANES=5, FIFO_DEPTH=2) with hand-written sequences for
// stall, same-cycle pop/push, reset and counter wrap corner cases.
// ---------------------------------------------------------------------------
module tb_lane_dispatch_rr;

  localparam int DW = 32;
  localparam int NL = 5;

  logic                clk;
  logic                rst;
  logic                inValid;
  logic                inReady;
  logic [DW-1:0]       inData;
  logic [NL-1:0]       outValid;
  logic [NL-1:0]       outReady;
  logic [NL*DW-1:0]    outData;
  logic [2:0]          rrPtr;
  logic [15:0]         acceptCnt;
  logic                idle;

  int checkCount = 0;
  int missCount  = 0;

  lane_dispatch_rr #(
    .DATA_W     (DW),
    .NUM_LANES  (NL),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .rr_ptr     (rrPtr),
    .accept_cnt (acceptCnt),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              inV;
    logic [31:0]       inD;
    logic [4:0]        outR;
    logic              expReady;
    logic [4:0]        expValid;
    logic [2:0]        expRr;
    logic [15:0]       expCnt;
    logic              expIdle;
    logic [4:0][31:0]  expData;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(logic r, logic v, logic [31:0] d, logic [4:0] o,
                                 logic er, logic [4:0] ev, logic [2:0] err,
                                 logic [15:0] ec, logic ei,
                                 logic [31:0] d4, logic [31:0] d3, logic [31:0] d2,
                                 logic [31:0] d1, logic [31:0] d0);
    vec_t t;
    t.rst = r; t.inV = v; t.inD = d; t.outR = o;
    t.expReady = er; t.expValid = ev; t.expRr = err; t.expCnt = ec; t.expIdle = ei;
    t.expData = {d4, d3, d2, d1, d0};
    return t;
  endfunction

  function automatic logic [31:0] laneData(int l);
    return outData[l*DW +: DW];
  endfunction

  // Drive inputs away from the active edge, step one rising edge, then
  // settle just after it so outputs reflect the new registered state.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                               input logic [4:0] o);
    @(negedge clk);
    rst = r; inValid = v; inData = d; outReady = o;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic er, input logic [4:0] ev,
                             input logic [2:0] err, input logic [15:0] ec,
                             input logic ei);
    checkOutput({tag, " in_ready"},   32'(inReady),   32'(er));
    checkOutput({tag, " out_valid"},  32'(outValid),  32'(ev));
    checkOutput({tag, " rr_ptr"},     32'(rrPtr),     32'(err));
    checkOutput({tag, " accept_cnt"}, 32'(acceptCnt), 32'(ec));
    checkOutput({tag, " idle"},       32'(idle),      32'(ei));
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; outReady = '0;

    // Reset, then five words with all consumers ready, then ten words with
    // all consumers stalled, then draining the two-deep lanes in order.
    tbl.push_back(mkVec(1,1,32'hFF,5'h1F, 1,5'b00000,0,0,1, 0,0,0,0,0));
    tbl.push_back(mkVec(1,0,32'h00,5'h00, 1,5'b00000,0,0,1, 0,0,0,0,0));
    tbl.push_back(mkVec(0,1,32'hA0,5'h1F, 1,5'b00001,1,1,0, 0,0,0,0,32'hA0));
    tbl.push_back(mkVec(0,1,32'hA1,5'h1F, 1,5'b00010,2,2,0, 0,0,0,32'hA1,0));
    tbl.push_back(mkVec(0,1,32'hA2,5'h1F, 1,5'b00100,3,3,0, 0,0,32'hA2,0,0));
    tbl.push_back(mkVec(0,1,32'hA3,5'h1F, 1,5'b01000,4,4,0, 0,32'hA3,0,0,0));
    tbl.push_back(mkVec(0,1,32'hA4,5'h1F, 1,5'b10000,0,5,0, 32'hA4,0,0,0,0));
    tbl.push_back(mkVec(0,0,32'h00,5'h1F, 1,5'b00000,0,5,1, 0,0,0,0,0));
    tbl.push_back(mkVec(0,1,32'hB0,5'h00, 1,5'b00001,1,6,0, 0,0,0,0,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB1,5'h00, 1,5'b00011,2,7,0, 0,0,0,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB2,5'h00, 1,5'b00111,3,8,0, 0,0,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB3,5'h00, 1,5'b01111,4,9,0, 0,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB4,5'h00, 1,5'b11111,0,10,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB5,5'h00, 1,5'b11111,1,11,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB6,5'h00, 1,5'b11111,2,12,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB7,5'h00, 1,5'b11111,3,13,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB8,5'h00, 1,5'b11111,4,14,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hB9,5'h00, 0,5'b11111,0,15,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,1,32'hC0,5'h00, 0,5'b11111,0,15,0, 32'hB4,32'hB3,32'hB2,32'hB1,32'hB0));
    tbl.push_back(mkVec(0,0,32'h00,5'h1F, 1,5'b11111,0,15,0, 32'hB9,32'hB8,32'hB7,32'hB6,32'hB5));
    tbl.push_back(mkVec(0,0,32'h00,5'h1F, 1,5'b00000,0,15,1, 0,0,0,0,0));

    foreach (tbl[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      applyStimulus(tbl[n].rst, tbl[n].inV, tbl[n].inD, tbl[n].outR);
      checkStatus(tag, tbl[n].expReady, tbl[n].expValid, tbl[n].expRr,
                  tbl[n].expCnt, tbl[n].expIdle);
      for (int l = 0; l < NL; l++) begin
        if (tbl[n].expValid[l]) begin
          checkOutput($sformatf("%s data lane%0d", tag, l), laneData(l),
                      tbl[n].expData[l]);
        end
      end
    end

    // Stall on a full lane two: fill every lane twice (F0..F9), free lanes
    // 0/1 and refill them (F10/F11) so rr_ptr sits at 2 with lane 2 full.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 32'hF0 + 32'(i), 5'h00);
    checkStatus("fill", 0, 5'b11111, 0, 25, 0);
    applyStimulus(0, 0, 32'h0, 5'b00011);
    applyStimulus(0, 1, 32'hFA, 5'h00);
    applyStimulus(0, 1, 32'hFB, 5'h00);
    checkStatus("rr2 setup", 0, 5'b11111, 2, 27, 0);
    applyStimulus(0, 1, 32'hE0, 5'h00);
    applyStimulus(0, 1, 32'hE0, 5'h00);
    checkStatus("stall lane2", 0, 5'b11111, 2, 27, 0);
    applyStimulus(0, 1, 32'hE0, 5'b00100);
    checkStatus("pop lane2", 1, 5'b11111, 2, 27, 0);
    checkOutput("pop lane2 head", laneData(2), 32'hF7);
    applyStimulus(0, 1, 32'hE0, 5'h00);
    checkStatus("push lane2", 0, 5'b11111, 3, 28, 0);
    checkOutput("push lane2 head", laneData(2), 32'hF7);

    // Full lane zero popping in the same cycle as a targeted input: the pop
    // happens, the push waits one cycle.
    applyStimulus(0, 0, 32'h0, 5'b11000);
    applyStimulus(0, 1, 32'hC0, 5'h00);
    applyStimulus(0, 1, 32'hC1, 5'h00);
    checkStatus("rr0 setup", 0, 5'b11111, 0, 30, 0);
    applyStimulus(0, 1, 32'hC2, 5'b00001);
    checkStatus("pop no push", 1, 5'b11111, 0, 30, 0);
    checkOutput("pop no push head", laneData(0), 32'hFA);
    applyStimulus(0, 1, 32'hC2, 5'h00);
    checkStatus("push after pop", 0, 5'b11111, 1, 31, 0);
    applyStimulus(0, 0, 32'h0, 5'b00001);
    checkOutput("lane0 order", laneData(0), 32'hC2);

    // Reset with seven words buffered discards them all.
    applyStimulus(1, 0, 32'h0, 5'h00);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 32'hD0 + 32'(i), 5'h00);
    checkStatus("seven buffered", 1, 5'b11111, 2, 7, 0);
    applyStimulus(1, 1, 32'hD7, 5'h1F);
    checkStatus("mid reset", 1, 5'b00000, 0, 0, 1);
    applyStimulus(0, 0, 32'h0, 5'h00);
    checkStatus("after release", 1, 5'b00000, 0, 0, 1);

    // Pop on empty lanes is ignored; same-cycle push and pop on lane zero
    // keeps its occupancy at one.
    applyStimulus(0, 0, 32'h0, 5'h1F);
    checkStatus("empty pop", 1, 5'b00000, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h50 + 32'(i), 5'h00);
    applyStimulus(0, 1, 32'h55, 5'b00001);
    checkStatus("push+pop", 1, 5'b11111, 1, 6, 0);
    checkOutput("push+pop head", laneData(0), 32'h55);
    applyStimulus(0, 0, 32'h0, 5'b00001);
    checkStatus("lane0 drained", 1, 5'b11110, 1, 6, 0);

    // accept_cnt wrap after 65536 transfers with every consumer ready.
    applyStimulus(1, 0, 32'h0, 5'h00);
    @(negedge clk);
    rst = 1'b0; inValid = 1'b1; inData = 32'h1234; outReady = 5'h1F;
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("cnt at ffff", 32'(acceptCnt), 32'hFFFF);
    checkOutput("rr at ffff", 32'(rrPtr), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("cnt wrap", 32'(acceptCnt), 32'h0000);
    checkOutput("rr after wrap", 32'(rrPtr), 32'd1);
    applyStimulus(0, 0, 32'h0, 5'h1F);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
